// File: rtl/vic_pkg.sv
// vic_pkg: register indices, reset constants and stack-entry sizing for vic_ctrl
package vic_pkg;
    localparam logic [2:0] VIC_PEND  = 3'd0;
    localparam logic [2:0] VIC_MASK  = 3'd1;
    localparam logic [2:0] VIC_CLR   = 3'd2;
    localparam logic [2:0] VIC_MODE  = 3'd3;
    localparam logic [2:0] VIC_VBASE = 3'd4;
    localparam logic [2:0] VIC_PIDX  = 3'd5;
    localparam logic [2:0] VIC_PRIO  = 3'd6;
    localparam logic [2:0] VIC_STAT  = 3'd7;
    localparam logic [15:0] VBASE_RST = 16'h0020;
    localparam int PRIO_RST = 1;
    // a stack entry is packed as {id, prio}
    function automatic int stk_w(int idw, int priw);
        return idw + priw;
    endfunction
endpackage

// File: rtl/vic_prio_arb.sv
// vic_prio_arb: combinational max-priority arbiter, ties resolved to the lowest index
// cand  : request per source
// prio  : priority per source
// valid : some request present; id/pri : winning source and its priority
module vic_prio_arb #(
    parameter int NSRC = 8,
    parameter int PRIW = 3
) (
    input  logic [NSRC-1:0]           cand,
    input  logic [NSRC-1:0][PRIW-1:0] prio,
    output logic                      valid,
    output logic [$clog2(NSRC)-1:0]   id,
    output logic [PRIW-1:0]           pri
);
    localparam int IDW = $clog2(NSRC);
    // strict compare while scanning upward keeps the lowest index on ties;
    // candidates arrive pre-filtered to nonzero priority
    always_comb begin
        valid = 1'b0;
        id = '0;
        pri = '0;
        for (int i = 0; i < NSRC; i++)
            if (cand[i] && prio[i] > pri) begin
                valid = 1'b1;
                id = IDW'(i);
                pri = prio[i];
            end
    end
endmodule

// File: rtl/vic_ctrl.sv
// vic_ctrl: vectored interrupt controller with programmable priority, edge/level sensing and nesting stack
// i_clk/i_rst           : clock, synchronous active-high reset
// i_sel/i_we/i_re/i_addr/i_wdata, o_rdata/o_rdy : MMIO register port, 1-cycle read latency
// i_src_irq             : raw interrupt lines
// i_int_en/i_irq_ret    : CPU global enable, return-from-interrupt pulse
// o_irq_take/o_irq_vector/o_irq_id : combinational take strobe, handler address, winning source
// o_depth               : current nesting depth
module vic_ctrl
    import vic_pkg::*;
#(
    parameter int          NSRC    = 8,
    parameter int          DEPTH   = 4,
    parameter int          PRIW    = 3,
    parameter logic [15:0] VSTRIDE = 16'h0020
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_sel,
    input  logic                       i_we,
    input  logic                       i_re,
    input  logic [2:0]                 i_addr,
    input  logic [15:0]                i_wdata,
    output logic [15:0]                o_rdata,
    output logic                       o_rdy,
    input  logic [NSRC-1:0]            i_src_irq,
    input  logic                       i_int_en,
    input  logic                       i_irq_ret,
    output logic                       o_irq_take,
    output logic [15:0]                o_irq_vector,
    output logic [$clog2(NSRC)-1:0]    o_irq_id,
    output logic [$clog2(DEPTH+1)-1:0] o_depth
);
    localparam int IDW = $clog2(NSRC);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int SW = stk_w(IDW, PRIW);
    localparam logic [DW-1:0] DMAX = DW'(DEPTH);
    localparam logic [15:0] NS16 = 16'(NSRC);

    logic [NSRC-1:0]           pend, mask, mode, src_q;
    logic [NSRC-1:0]           in_stk, set, cand, pri_nz, pend_n;
    logic [NSRC-1:0][PRIW-1:0] pri;
    logic [DEPTH-1:0][SW-1:0]  stk;
    logic [15:0]               vbase, pidx, rd_val;
    logic [DW-1:0]             depth, eff;
    logic [IDW-1:0]            win_id;
    logic [PRIW-1:0]           win_pri, cur_pri;
    logic                      win_valid, take, wr;

    // sources already being serviced must not re-pend while their level is held
    always_comb begin
        in_stk = '0;
        pri_nz = '0;
        for (int k = 0; k < DEPTH; k++)
            if (DW'(k) < depth) in_stk[stk[k][SW-1 -: IDW]] = 1'b1;
        for (int i = 0; i < NSRC; i++) pri_nz[i] = |pri[i];
    end

    assign set  = (mode & i_src_irq & ~src_q) | (~mode & i_src_irq & mask & ~in_stk);
    assign cand = (pend | set) & mask & pri_nz;

    vic_prio_arb #(.NSRC(NSRC), .PRIW(PRIW)) u_arb (
        .cand(cand), .prio(pri), .valid(win_valid), .id(win_id), .pri(win_pri)
    );

    // a coinciding return is folded in first, so a take can replace the popped entry
    assign eff     = (i_irq_ret && depth != '0) ? depth - DW'(1) : depth;
    assign cur_pri = (eff == '0) ? '0 : stk[eff - DW'(1)][PRIW-1:0];
    assign take    = ~i_rst & win_valid & i_int_en & (win_pri > cur_pri) & (eff < DMAX);

    assign o_irq_take   = take;
    assign o_irq_id     = take ? win_id : '0;
    assign o_irq_vector = take ? vbase + 16'(win_id) * VSTRIDE : 16'hFFFF;
    assign o_depth      = depth;
    assign o_rdy        = i_sel;
    assign wr           = i_sel & i_we;

    // take-clear, then PEND write-set, then CLR so a clear always wins
    assign pend_n = (((pend | set) & ~(take ? NSRC'(1) << win_id : '0))
                     | ((wr && i_addr == VIC_PEND) ? i_wdata[NSRC-1:0] : '0))
                    & ~((wr && i_addr == VIC_CLR) ? i_wdata[NSRC-1:0] : '0);

    always_comb begin
        rd_val = '0;
        case (i_addr)
            VIC_PEND:  rd_val = 16'(pend);
            VIC_MASK:  rd_val = 16'(mask);
            VIC_MODE:  rd_val = 16'(mode);
            VIC_VBASE: rd_val = vbase;
            VIC_PIDX:  rd_val = pidx;
            VIC_PRIO:  rd_val = (pidx < NS16) ? 16'(pri[pidx[IDW-1:0]]) : '0;
            VIC_STAT:  rd_val = {8'h0, 4'(depth), 4'(cur_pri)};
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend    <= '0;
            mask    <= '1;
            mode    <= '0;
            src_q   <= '0;
            vbase   <= VBASE_RST;
            pidx    <= '0;
            pri     <= {NSRC{PRIW'(PRIO_RST)}};
            stk     <= '0;
            depth   <= '0;
            o_rdata <= '0;
        end else begin
            src_q   <= i_src_irq;
            pend    <= pend_n;
            o_rdata <= (i_sel && i_re) ? rd_val : '0;
            depth   <= take ? eff + DW'(1) : eff;
            if (take) stk[eff] <= {win_id, win_pri};
            if (wr && i_addr == VIC_MASK) mask <= i_wdata[NSRC-1:0];
            if (wr && i_addr == VIC_MODE) mode <= i_wdata[NSRC-1:0];
            if (wr && i_addr == VIC_VBASE) vbase <= i_wdata;
            if (wr && i_addr == VIC_PIDX) pidx <= i_wdata;
            if (wr && i_addr == VIC_PRIO && pidx < NS16) pri[pidx[IDW-1:0]] <= i_wdata[PRIW-1:0];
        end
    end
endmodule

// File: tb/tb_vic_ctrl.sv
// tb_vic_ctrl: directed self-checking bench for vic_ctrl
module tb_vic_ctrl;
    logic        clk = 1'b0, rst = 1'b1, sel = 1'b0, we = 1'b0, re = 1'b0;
    logic        int_en = 1'b0, ret = 1'b0;
    logic [2:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [7:0]  src = '0;
    logic [15:0] rdata, vec;
    logic        rdy, take;
    logic [2:0]  id, depth;
    int          checks = 0, failures = 0;
    int          ids[4] = '{0, 1, 2, 4};

    always #5 clk = ~clk;

    vic_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_sel(sel), .i_we(we), .i_re(re), .i_addr(addr),
        .i_wdata(wdata), .o_rdata(rdata), .o_rdy(rdy), .i_src_irq(src), .i_int_en(int_en),
        .i_irq_ret(ret), .o_irq_take(take), .o_irq_vector(vec), .o_irq_id(id), .o_depth(depth)
    );

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [2:0] a, logic [15:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        step();
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rdchk(string tag, logic [2:0] a, logic [15:0] exp);
        sel = 1'b1; re = 1'b1; addr = a;
        step();
        sel = 1'b0; re = 1'b0;
        check(tag, rdata, exp);
    endtask

    task automatic expect_take(string tag, logic t, logic [2:0] i, logic [15:0] v);
        #1;
        check({tag, "_take"}, 16'(take), 16'(t));
        check({tag, "_id"}, 16'(id), 16'(i));
        check({tag, "_vec"}, vec, v);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_vec", vec, 16'hFFFF);
        check("rst_depth", 16'(depth), 16'h0);
        rdchk("rst_mask", 3'd1, 16'h00FF);
        rdchk("rst_vbase", 3'd4, 16'h0020);
        rdchk("rst_prio0", 3'd6, 16'h0001);
        rdchk("rst_stat", 3'd7, 16'h0000);
        step();
        check("rdata_idle", rdata, 16'h0);
        sel = 1'b1;
        #1;
        check("rdy", 16'(rdy), 16'h1);
        sel = 1'b0;

        int_en = 1'b1; src = 8'h24;
        expect_take("tie", 1'b1, 3'd2, 16'h0060);
        step();
        src = '0;
        expect_take("tie_hold", 1'b0, 3'd0, 16'hFFFF);
        check("tie_depth", 16'(depth), 16'h1);
        ret = 1'b1;
        expect_take("tie_ret", 1'b1, 3'd5, 16'h00C0);
        step();
        check("tie_ret_depth", 16'(depth), 16'h1);
        step();
        ret = 1'b0;
        check("tie_unwind", 16'(depth), 16'h0);

        int_en = 1'b0;
        wr(3'd4, 16'h1000);
        int_en = 1'b1; src = 8'h20;
        expect_take("vbase", 1'b1, 3'd5, 16'h10A0);
        step();
        src = '0; ret = 1'b1;
        step();
        ret = 1'b0;

        int_en = 1'b0;
        wr(3'd5, 16'd3); wr(3'd6, 16'd2);
        wr(3'd5, 16'd6); wr(3'd6, 16'd5);
        int_en = 1'b1; src = 8'h08;
        expect_take("n3", 1'b1, 3'd3, 16'h1060);
        step();
        src = '0;
        rdchk("n3_stat", 3'd7, 16'h0012);
        src = 8'h40;
        expect_take("n6", 1'b1, 3'd6, 16'h10C0);
        step();
        src = 8'h08;
        check("n6_depth", 16'(depth), 16'h2);
        expect_take("n3_blk", 1'b0, 3'd0, 16'hFFFF);
        step();
        ret = 1'b1;
        expect_take("n3_ret1", 1'b0, 3'd0, 16'hFFFF);
        step();
        expect_take("n3_ret2", 1'b0, 3'd0, 16'hFFFF);
        step();
        ret = 1'b0;
        check("n3_depth0", 16'(depth), 16'h0);
        expect_take("n3_repend", 1'b1, 3'd3, 16'h1060);
        step();
        src = '0; ret = 1'b1;
        step();
        ret = 1'b0;

        int_en = 1'b0;
        wr(3'd5, 16'd1); wr(3'd6, 16'd2);
        wr(3'd5, 16'd2); wr(3'd6, 16'd3);
        wr(3'd5, 16'd4); wr(3'd6, 16'd4);
        wr(3'd5, 16'd7); wr(3'd6, 16'd6);
        int_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            src = 8'(1 << ids[k]);
            expect_take("full_push", 1'b1, 3'(ids[k]), 16'h1000 + 16'(ids[k] * 32));
            step();
            src = '0;
        end
        check("full_depth", 16'(depth), 16'h4);
        src = 8'h80;
        expect_take("full_blk", 1'b0, 3'd0, 16'hFFFF);
        step();
        src = '0;
        rdchk("full_pend", 3'd0, 16'h0080);
        ret = 1'b1;
        expect_take("full_ret", 1'b1, 3'd7, 16'h10E0);
        step();
        check("full_ret_depth", 16'(depth), 16'h4);
        for (int k = 0; k < 4; k++) step();
        ret = 1'b0;
        check("full_unwind", 16'(depth), 16'h0);

        src = 8'h01;
        expect_take("lvl", 1'b1, 3'd0, 16'h1000);
        step();
        expect_take("lvl_hold", 1'b0, 3'd0, 16'hFFFF);
        step();
        ret = 1'b1;
        expect_take("lvl_ret", 1'b0, 3'd0, 16'hFFFF);
        step();
        ret = 1'b0;
        expect_take("lvl_retake", 1'b1, 3'd0, 16'h1000);
        step();
        src = '0; ret = 1'b1;
        step();
        ret = 1'b0;

        int_en = 1'b0;
        wr(3'd3, 16'h0002);
        rdchk("mode", 3'd3, 16'h0002);
        int_en = 1'b1; src = 8'h02;
        expect_take("edg", 1'b1, 3'd1, 16'h1020);
        step();
        ret = 1'b1;
        expect_take("edg_ret", 1'b0, 3'd0, 16'hFFFF);
        step();
        ret = 1'b0;
        expect_take("edg_after", 1'b0, 3'd0, 16'hFFFF);
        check("edg_depth", 16'(depth), 16'h0);
        src = '0;
        step();

        int_en = 1'b0;
        wr(3'd0, 16'h0005);
        rdchk("pend_set", 3'd0, 16'h0005);
        wr(3'd2, 16'h0001);
        rdchk("pend_clr", 3'd0, 16'h0004);
        rdchk("clr_read", 3'd2, 16'h0000);
        wr(3'd2, 16'h0004);
        int_en = 1'b1; src = 8'h01;
        wr(3'd0, 16'h0001);
        src = '0; int_en = 1'b0;
        rdchk("pend_over_take", 3'd0, 16'h0001);
        wr(3'd2, 16'h0001);
        ret = 1'b1;
        step();
        check("ret_pop", 16'(depth), 16'h0);
        step();
        ret = 1'b0;
        check("ret_at0", 16'(depth), 16'h0);

        wr(3'd5, 16'd9);
        rdchk("prio_oob", 3'd6, 16'h0000);
        wr(3'd6, 16'd7);
        wr(3'd5, 16'd0);
        rdchk("prio0_kept", 3'd6, 16'h0001);

        int_en = 1'b1; src = 8'h01;
        step();
        check("mid_depth", 16'(depth), 16'h1);
        rst = 1'b1;
        #1;
        check("rst_take", 16'(take), 16'h0);
        step();
        rst = 1'b0; src = '0;
        check("rst_mid_depth", 16'(depth), 16'h0);
        rdchk("rst_mid_pend", 3'd0, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
